// File: rtl/spd_filt_sched_if.sv
// Handshake and state bus between the sample-rate controller and the
// DMS/DML adaptation-speed filter sequencer.
interface spd_filt_sched_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [2:0]       fi;
    logic             init;
    logic             busy;
    logic             done;
    logic             start_err;
    logic [11:0]      dms;
    logic [13:0]      dml;
    logic [CNT_W-1:0] upd_cnt;

    // Sample-rate controller side: issues requests, observes filter state.
    modport master (
        output start, fi, init,
        input  busy, done, start_err, dms, dml, upd_cnt
    );

    // Filter sequencer side.
    modport slave (
        input  start, fi, init,
        output busy, done, start_err, dms, dml, upd_cnt
    );
endinterface

// File: rtl/spd_filt_sched.sv
// G.726 adaptation-speed control: short-term (DMS) and long-term (DML)
// averaging filters. One shared subtract/shift/add unit is used in state A
// for FILTA (DMS) and in state B for FILTB (DML); a sample takes 4 cycles
// from an accepted start to the next possible accept.
module spd_filt_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    spd_filt_sched_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_A    = 2'd1;
    localparam logic [1:0] S_B    = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [2:0]       fi_q, fi_d;
    logic [11:0]      dms_q, dms_d;
    logic [13:0]      dml_q, dml_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [13:0]      unit_res;
    logic             busy_w;

    // Shared filter unit: DIF = (FI << k) - state, DIFSX = DIF >>> s,
    // result = DIFSX + state. The true difference always fits the signed
    // 15-bit range, so one signed subtractor serves both the 13-bit (FILTA)
    // and 15-bit (FILTB) modulo forms. The 14-bit sum is exact for DML and
    // its low 12 bits are the modulo-2^12 result for DMS.
    function automatic logic [13:0] filt_unit(
        input logic        sel_b,
        input logic [2:0]  fi,
        input logic [11:0] dms,
        input logic [13:0] dml
    );
        logic        [14:0] op_a;
        logic        [13:0] op_b;
        logic signed [14:0] dif;
        logic        [13:0] difsx;
        if (sel_b) begin
            op_a = {1'b0, fi, 11'd0};
            op_b = dml;
        end else begin
            op_a = {3'd0, fi, 9'd0};
            op_b = {2'b00, dms};
        end
        dif   = $signed(op_a - {1'b0, op_b});
        difsx = sel_b ? 14'(dif >>> 7) : 14'(dif >>> 5);
        return difsx + op_b;
    endfunction

    assign unit_res = filt_unit(state_q == S_B, fi_q, dms_q, dml_q);

    // Next-state logic: init clears the filter state and discards any request.
    always_comb begin
        state_d = state_q;
        fi_d    = fi_q;
        dms_d   = dms_q;
        dml_d   = dml_q;
        cnt_d   = cnt_q;
        if (bus.init) begin
            state_d = S_IDLE;
            fi_d    = 3'd0;
            dms_d   = 12'd0;
            dml_d   = 14'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        fi_d    = bus.fi;
                        state_d = S_A;
                    end
                end
                S_A: begin
                    dms_d   = unit_res[11:0];
                    state_d = S_B;
                end
                S_B: begin
                    // Count on entry to DONE so upd_cnt agrees with the done pulse.
                    dml_d   = unit_res;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and filter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            fi_q    <= 3'd0;
            dms_q   <= 12'd0;
            dml_q   <= 14'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fi_q    <= fi_d;
            dms_q   <= dms_d;
            dml_q   <= dml_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_w        = (state_q != S_IDLE);
    assign bus.busy      = busy_w;
    assign bus.done      = (state_q == S_DONE);
    // A request arriving mid-update is dropped and flagged; init and reset
    // take precedence and silence the flag.
    assign bus.start_err = bus.start & busy_w & ~bus.init & ~reset;
    assign bus.dms       = dms_q;
    assign bus.dml       = dml_q;
    assign bus.upd_cnt   = cnt_q;

endmodule

// File: tb/tb_spd_filt_sched.sv
// Self-checking bench for spd_filt_sched with a behavioural G.726 FILTA/FILTB
// reference model.
module tb_spd_filt_sched;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [11:0]      m_dms = '0;
    logic [13:0]      m_dml = '0;
    logic [CNT_W-1:0] m_cnt = '0;

    always #5 clk = ~clk;

    spd_filt_sched_if #(.CNT_W(CNT_W)) bus ();

    spd_filt_sched #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // FILTA in the G.726 form: 13-bit modular difference, shift by 5 with
    // the 0xF00 sign fill when negative, 12-bit modular sum.
    function automatic int ref_dms(input int fi, input int dms);
        int dif, sx;
        dif = (fi * 512 - dms + 8192) % 8192;
        if (dif >= 4096) sx = ((dif >> 5) + 'hF00) % 4096;
        else             sx = dif >> 5;
        return (sx + dms) % 4096;
    endfunction

    // FILTB: 15-bit modular difference, shift by 7 with 0x3F00 sign fill.
    function automatic int ref_dml(input int fi, input int dml);
        int dif, sx;
        dif = (fi * 2048 - dml + 32768) % 32768;
        if (dif >= 16384) sx = ((dif >> 7) + 'h3F00) % 16384;
        else              sx = dif >> 7;
        return (sx + dml) % 16384;
    endfunction

    task automatic model_update(input int f);
        m_dms = 12'(ref_dms(f, int'(m_dms)));
        m_dml = 14'(ref_dml(f, int'(m_dml)));
        m_cnt = m_cnt + 1'b1;
    endtask

    task automatic model_clear();
        m_dms = '0;
        m_dml = '0;
    endtask

    // Pulse start for one cycle; returns at the negedge where state is A.
    task automatic issue_start(input logic [2:0] f);
        @(negedge clk);
        bus.start = 1'b1;
        bus.fi    = f;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.init  = 1'b0;
        bus.fi    = 3'd0;
        repeat (2) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus.done); end
        total++; if (bus.start_err !== 1'b0) begin bad++; $display("FAIL rst_serr got=%b want=0", bus.start_err); end
        total++; if (bus.dms !== 12'h000) begin bad++; $display("FAIL rst_dms got=%h want=000", bus.dms); end
        total++; if (bus.dml !== 14'h0000) begin bad++; $display("FAIL rst_dml got=%h want=0000", bus.dml); end
        total++; if (bus.upd_cnt !== '0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", bus.upd_cnt); end
        reset = 1'b0;
        model_clear();
        m_cnt = '0;
    endtask

    // Known G.726 values, latency and busy length.
    task automatic test_known();
        int kfi[3]  = '{7, 7, 0};
        int kdms[3] = '{'h070, 'h0DC, 'h0D5};
        int kdml[3] = '{'h070, 'h0DF, 'h0DD};
        for (int k = 0; k < 3; k++) begin
            int bc = 0;
            int dc = 0;
            issue_start(3'(kfi[k]));
            model_update(kfi[k]);
            for (int c = 1; c <= 5; c++) begin
                if (c > 1) @(negedge clk);
                if (bus.busy) bc++;
                if (bus.done && dc == 0) begin
                    dc = c;
                    total++; if (bus.dms !== 12'(kdms[k])) begin bad++; $display("FAIL known_dms[%0d] got=%h want=%h", k, bus.dms, 12'(kdms[k])); end
                    total++; if (bus.dml !== 14'(kdml[k])) begin bad++; $display("FAIL known_dml[%0d] got=%h want=%h", k, bus.dml, 14'(kdml[k])); end
                    total++; if (bus.upd_cnt !== CNT_W'(k + 1)) begin bad++; $display("FAIL known_cnt[%0d] got=%0d want=%0d", k, bus.upd_cnt, k + 1); end
                end
            end
            total++; if (dc != 3) begin bad++; $display("FAIL known_lat[%0d] got=%0d want=3", k, dc); end
            total++; if (bc != 3) begin bad++; $display("FAIL known_busy[%0d] got=%0d want=3", k, bc); end
        end
    endtask

    task automatic test_start_err();
        logic [2:0] fa, fb;
        fa = 3'($urandom_range(0, 7));
        fb = 3'($urandom_range(0, 7));
        issue_start(fa);
        model_update(fa);
        for (int k = 0; k < 3; k++) begin
            bus.start = 1'b1;
            bus.fi    = 3'($urandom_range(0, 7));
            #1;
            total++; if (bus.start_err !== 1'b1) begin bad++; $display("FAIL serr_busy[%0d] got=%b want=1", k, bus.start_err); end
            if (k == 2) begin
                total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL serr_done got=%b want=1", bus.done); end
                total++; if (bus.dms !== m_dms) begin bad++; $display("FAIL serr_dms got=%h want=%h", bus.dms, m_dms); end
                total++; if (bus.dml !== m_dml) begin bad++; $display("FAIL serr_dml got=%h want=%h", bus.dml, m_dml); end
                total++; if (bus.upd_cnt !== m_cnt) begin bad++; $display("FAIL serr_cnt got=%0d want=%0d", bus.upd_cnt, m_cnt); end
            end
            @(negedge clk);
        end
        // Back in IDLE with start still high: this one must be accepted.
        bus.fi = fb;
        #1;
        total++; if (bus.start_err !== 1'b0) begin bad++; $display("FAIL serr_idle got=%b want=0", bus.start_err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL serr_idle_busy got=%b want=0", bus.busy); end
        @(negedge clk);
        bus.start = 1'b0;
        model_update(fb);
        repeat (2) @(negedge clk);
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL serr_next_done got=%b want=1", bus.done); end
        total++; if (bus.dms !== m_dms) begin bad++; $display("FAIL serr_next_dms got=%h want=%h", bus.dms, m_dms); end
        total++; if (bus.dml !== m_dml) begin bad++; $display("FAIL serr_next_dml got=%h want=%h", bus.dml, m_dml); end
        total++; if (bus.upd_cnt !== m_cnt) begin bad++; $display("FAIL serr_next_cnt got=%0d want=%0d", bus.upd_cnt, m_cnt); end
    endtask

    task automatic test_init();
        logic [2:0] f;
        int dn;
        // init (with a competing start) while in state A.
        issue_start(3'($urandom_range(1, 7)));
        bus.init  = 1'b1;
        bus.start = 1'b1;
        bus.fi    = 3'($urandom_range(0, 7));
        #1;
        total++; if (bus.start_err !== 1'b0) begin bad++; $display("FAIL init_a_serr got=%b want=0", bus.start_err); end
        @(negedge clk);
        bus.init  = 1'b0;
        bus.start = 1'b0;
        model_clear();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL init_a_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL init_a_done got=%b want=0", bus.done); end
        total++; if (bus.dms !== 12'h000) begin bad++; $display("FAIL init_a_dms got=%h want=000", bus.dms); end
        total++; if (bus.dml !== 14'h0000) begin bad++; $display("FAIL init_a_dml got=%h want=0000", bus.dml); end
        total++; if (bus.upd_cnt !== m_cnt) begin bad++; $display("FAIL init_a_cnt got=%0d want=%0d", bus.upd_cnt, m_cnt); end

        // init in state B, after DMS has already been updated.
        issue_start(3'd7);
        @(negedge clk);
        total++; if (bus.dms !== 12'(ref_dms(7, 0))) begin bad++; $display("FAIL init_b_dms_lead got=%h want=%h", bus.dms, 12'(ref_dms(7, 0))); end
        total++; if (bus.dml !== 14'h0000) begin bad++; $display("FAIL init_b_dml_lag got=%h want=0000", bus.dml); end
        bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL init_b_busy got=%b want=0", bus.busy); end
        total++; if (bus.dms !== 12'h000) begin bad++; $display("FAIL init_b_dms got=%h want=000", bus.dms); end
        total++; if (bus.dml !== 14'h0000) begin bad++; $display("FAIL init_b_dml got=%h want=0000", bus.dml); end
        total++; if (bus.upd_cnt !== m_cnt) begin bad++; $display("FAIL init_b_cnt got=%0d want=%0d", bus.upd_cnt, m_cnt); end
        dn = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        total++; if (dn != 0) begin bad++; $display("FAIL init_b_nodone got=%0d want=0", dn); end

        // init together with start in IDLE, with non-zero state to clear.
        f = 3'($urandom_range(1, 7));
        issue_start(f);
        model_update(f);
        repeat (3) @(negedge clk);
        total++; if (bus.dms !== m_dms) begin bad++; $display("FAIL init_i_pre_dms got=%h want=%h", bus.dms, m_dms); end
        bus.init  = 1'b1;
        bus.start = 1'b1;
        bus.fi    = 3'd7;
        #1;
        total++; if (bus.start_err !== 1'b0) begin bad++; $display("FAIL init_i_serr got=%b want=0", bus.start_err); end
        @(negedge clk);
        bus.init  = 1'b0;
        bus.start = 1'b0;
        model_clear();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL init_i_busy got=%b want=0", bus.busy); end
        total++; if (bus.dms !== 12'h000) begin bad++; $display("FAIL init_i_dms got=%h want=000", bus.dms); end
        total++; if (bus.dml !== 14'h0000) begin bad++; $display("FAIL init_i_dml got=%h want=0000", bus.dml); end
        total++; if (bus.upd_cnt !== m_cnt) begin bad++; $display("FAIL init_i_cnt got=%0d want=%0d", bus.upd_cnt, m_cnt); end
        dn = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        total++; if (dn != 0) begin bad++; $display("FAIL init_i_idle got=%0d want=0", dn); end
    endtask

    task automatic test_random();
        logic [2:0] f;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            f = 3'($urandom_range(0, 7));
            issue_start(f);
            model_update(f);
            repeat (2) @(negedge clk);
            total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL rnd_done[%0d] got=%b want=1", i, bus.done); end
            total++; if (bus.dms !== m_dms) begin bad++; $display("FAIL rnd_dms[%0d] fi=%0d got=%h want=%h", i, f, bus.dms, m_dms); end
            total++; if (bus.dml !== m_dml) begin bad++; $display("FAIL rnd_dml[%0d] fi=%0d got=%h want=%h", i, f, bus.dml, m_dml); end
            total++; if (bus.upd_cnt !== m_cnt) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d want=%0d", i, bus.upd_cnt, m_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        issue_start(3'($urandom_range(0, 7)));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        m_cnt = '0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b want=0", bus.done); end
        total++; if (bus.start_err !== 1'b0) begin bad++; $display("FAIL rmid_serr got=%b want=0", bus.start_err); end
        total++; if (bus.dms !== 12'h000) begin bad++; $display("FAIL rmid_dms got=%h want=000", bus.dms); end
        total++; if (bus.dml !== 14'h0000) begin bad++; $display("FAIL rmid_dml got=%h want=0000", bus.dml); end
        total++; if (bus.upd_cnt !== '0) begin bad++; $display("FAIL rmid_cnt got=%0d want=0", bus.upd_cnt); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        total++; if (dn != 0) begin bad++; $display("FAIL rmid_nodone got=%0d want=0", dn); end
    endtask

    task automatic test_back_to_back();
        int n = (1 << CNT_W) + 3;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        m_cnt = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle[%0d] got=%b want=0", i, bus.busy); end
            bus.start = 1'b1;
            bus.fi    = 3'(i % 8);
            @(negedge clk);
            bus.start = 1'b0;
            model_update(i % 8);
            repeat (2) @(negedge clk);
            total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_done[%0d] got=%b want=1", i, bus.done); end
            total++; if (bus.dms !== m_dms) begin bad++; $display("FAIL b2b_dms[%0d] got=%h want=%h", i, bus.dms, m_dms); end
            total++; if (bus.dml !== m_dml) begin bad++; $display("FAIL b2b_dml[%0d] got=%h want=%h", i, bus.dml, m_dml); end
            total++; if (bus.upd_cnt !== m_cnt) begin bad++; $display("FAIL b2b_cnt[%0d] got=%0d want=%0d", i, bus.upd_cnt, m_cnt); end
        end
        total++; if (bus.upd_cnt !== CNT_W'(3)) begin bad++; $display("FAIL b2b_wrap got=%0d want=3", bus.upd_cnt); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.init  = 1'b0;
        bus.fi    = 3'd0;
        test_reset();
        test_known();
        test_start_err();
        test_init();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
